// File: rtl/jtframe_sdram_1bank_ctrl_if.sv
// ----------------------------------------------------------------------------
// jtframe_sdram_1bank_ctrl_if
// Request/response bus between the RAM/ROM arbiter and the single-bank SDRAM
// controller.
//   rd, wr    : access requests, held by the arbiter until ack
//   addr      : word address {row, col[8:0]}
//   din       : write data
//   wrmask    : byte mask, 1 = byte not written
//   ack       : one-cycle pulse, request accepted (addr/din/wrmask latched)
//   data_dst  : one-cycle pulse, read data valid on dout
//   data_rdy  : one-cycle pulse, access complete
//   dout      : registered read data
// master = arbiter side, slave = controller side.
// ----------------------------------------------------------------------------
interface jtframe_sdram_1bank_ctrl_if #(
  parameter int SDRAMW = 22
);
  logic              rd;
  logic              wr;
  logic [SDRAMW-1:0] addr;
  logic [15:0]       din;
  logic [1:0]        wrmask;
  logic              ack;
  logic              data_dst;
  logic              data_rdy;
  logic [15:0]       dout;

  modport master (
    output rd, wr, addr, din, wrmask,
    input  ack, data_dst, data_rdy, dout
  );

  modport slave (
    input  rd, wr, addr, din, wrmask,
    output ack, data_dst, data_rdy, dout
  );
endinterface

// File: rtl/jtframe_sdram_1bank_ctrl.sv
// ----------------------------------------------------------------------------
// jtframe_sdram_1bank_ctrl
// Single-bank SDRAM command sequencer. Performs power-up initialisation,
// periodic auto-refresh and single-word accesses, each one ACTIVATE followed
// by READ/WRITE with auto-precharge.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : arbiter request/response bus
//   init_done         : high once the mode register has been loaded
//   sdram_cs_n/ras_n/cas_n/we_n, sdram_ba, sdram_a, sdram_dqm : command pins
//   sdram_dq_out, sdram_dq_oe, sdram_dq_in                    : data pad
// All SDRAM-facing outputs are registered.
// ----------------------------------------------------------------------------
module jtframe_sdram_1bank_ctrl #(
  parameter int SDRAMW     = 22,
  parameter int BANK       = 0,
  parameter int CL         = 2,
  parameter int TRCD       = 2,
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int TWR        = 2,
  parameter int REF_CYCLES = 374,
  parameter int INIT_WAIT  = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  jtframe_sdram_1bank_ctrl_if.slave bus,
  output logic        init_done,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  input  logic [15:0] sdram_dq_in
);

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_ACT  = 3'b011;
  localparam logic [2:0] CMD_RD   = 3'b101;
  localparam logic [2:0] CMD_WR   = 3'b100;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_REF  = 3'b001;
  localparam logic [2:0] CMD_MODE = 3'b000;

  // Single-location write burst, CAS latency CL, sequential, burst length 1
  localparam logic [12:0] MODE_WORD = {3'b000, 1'b1, 2'b00, 3'(CL), 1'b0, 3'b000};

  // Auto-precharge of a BL1 read starts right after the READ; only precharge
  // time not already covered by the data return needs an extra wait.
  localparam int RD_TAIL = (TRP > CL + 2) ? TRP - CL - 2 : 0;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF,
    ST_INIT_MODE,
    ST_IDLE,
    ST_REF,
    ST_TRCD,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_RD_TAIL,
    ST_WR_WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic              ref_num_reg, ref_num_next;
  logic [15:0]       ref_cnt_reg, ref_cnt_next;
  logic              ref_pend_reg, ref_pend_next;
  logic              is_wr_reg, is_wr_next;
  logic [SDRAMW-1:0] addr_reg, addr_next;
  logic [15:0]       din_reg, din_next;
  logic [1:0]        mask_reg, mask_next;
  logic [2:0]        cmd_reg, cmd_next;
  logic [12:0]       a_reg, a_next;
  logic [1:0]        dqm_reg, dqm_next;
  logic              dq_oe_reg, dq_oe_next;
  logic [15:0]       dq_out_reg, dq_out_next;
  logic              ack_reg, ack_next;
  logic              dst_reg, dst_next;
  logic              rdy_reg, rdy_next;
  logic [15:0]       dout_reg, dout_next;
  logic              init_done_reg, init_done_next;

  logic              cnt_zero;
  logic              ref_issue;
  logic              ref_expire;

  assign cnt_zero = (cnt_reg == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT_WAIT;
      cnt_reg       <= 16'(INIT_WAIT - 1);
      ref_num_reg   <= 1'b0;
      ref_cnt_reg   <= 16'(REF_CYCLES);
      ref_pend_reg  <= 1'b0;
      is_wr_reg     <= 1'b0;
      addr_reg      <= '0;
      din_reg       <= 16'd0;
      mask_reg      <= 2'b11;
      cmd_reg       <= CMD_NOP;
      a_reg         <= 13'd0;
      dqm_reg       <= 2'b11;
      dq_oe_reg     <= 1'b0;
      dq_out_reg    <= 16'd0;
      ack_reg       <= 1'b0;
      dst_reg       <= 1'b0;
      rdy_reg       <= 1'b0;
      dout_reg      <= 16'd0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ref_num_reg   <= ref_num_next;
      ref_cnt_reg   <= ref_cnt_next;
      ref_pend_reg  <= ref_pend_next;
      is_wr_reg     <= is_wr_next;
      addr_reg      <= addr_next;
      din_reg       <= din_next;
      mask_reg      <= mask_next;
      cmd_reg       <= cmd_next;
      a_reg         <= a_next;
      dqm_reg       <= dqm_next;
      dq_oe_reg     <= dq_oe_next;
      dq_out_reg    <= dq_out_next;
      ack_reg       <= ack_next;
      dst_reg       <= dst_next;
      rdy_reg       <= rdy_next;
      dout_reg      <= dout_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_zero ? cnt_reg : cnt_reg - 16'd1;
    ref_num_next   = ref_num_reg;
    is_wr_next     = is_wr_reg;
    addr_next      = addr_reg;
    din_next       = din_reg;
    mask_next      = mask_reg;
    cmd_next       = CMD_NOP;
    a_next         = a_reg;
    dqm_next       = 2'b11;
    dq_oe_next     = 1'b0;
    dq_out_next    = dq_out_reg;
    ack_next       = 1'b0;
    dst_next       = 1'b0;
    rdy_next       = 1'b0;
    dout_next      = dout_reg;
    init_done_next = init_done_reg;
    ref_issue      = 1'b0;

    // Wait counters hold (spacing - 1); the next command issues on the edge
    // that finds the counter at zero.
    case (state_reg)
      ST_INIT_WAIT: if (cnt_zero) begin
        cmd_next   = CMD_PRE;
        a_next     = 13'h0400;            // A10: all banks
        cnt_next   = 16'(TRP - 1);
        state_next = ST_INIT_PRE;
      end
      ST_INIT_PRE: if (cnt_zero) begin
        cmd_next     = CMD_REF;
        cnt_next     = 16'(TRFC);         // TRFC idle cycles after REFRESH
        ref_num_next = 1'b0;
        state_next   = ST_INIT_REF;
      end
      ST_INIT_REF: if (cnt_zero) begin
        if (!ref_num_reg) begin
          cmd_next     = CMD_REF;
          cnt_next     = 16'(TRFC);
          ref_num_next = 1'b1;
        end else begin
          cmd_next   = CMD_MODE;
          a_next     = MODE_WORD;
          cnt_next   = 16'd1;
          state_next = ST_INIT_MODE;
        end
      end
      ST_INIT_MODE: if (cnt_zero) begin
        init_done_next = 1'b1;
        state_next     = ST_IDLE;
      end
      ST_IDLE: begin
        if (ref_pend_reg) begin
          cmd_next   = CMD_REF;
          ref_issue  = 1'b1;
          cnt_next   = 16'(TRFC - 1);
          state_next = ST_REF;
        end else if (bus.wr || bus.rd) begin
          cmd_next   = CMD_ACT;
          a_next     = 13'(bus.addr[SDRAMW-1:9]);
          ack_next   = 1'b1;
          is_wr_next = bus.wr;            // rd+wr together is a write
          addr_next  = bus.addr;
          din_next   = bus.din;
          mask_next  = bus.wrmask;
          cnt_next   = 16'(TRCD - 1);
          state_next = ST_TRCD;
        end
      end
      ST_REF: if (cnt_zero) state_next = ST_IDLE;
      ST_TRCD: if (cnt_zero) begin
        a_next = {2'b00, 1'b1, 1'b0, addr_reg[8:0]};   // A10: auto-precharge
        if (is_wr_reg) begin
          cmd_next    = CMD_WR;
          dq_oe_next  = 1'b1;
          dq_out_next = din_reg;
          dqm_next    = mask_reg;
          cnt_next    = 16'(TWR + TRP - 1);
          state_next  = ST_WR_WAIT;
        end else begin
          cmd_next   = CMD_RD;
          dqm_next   = 2'b00;
          cnt_next   = 16'(CL);
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // DQM has a read latency of two; keep it open until the data returns
        if (cnt_zero) begin
          dout_next  = sdram_dq_in;
          dst_next   = 1'b1;
          state_next = ST_RD_DONE;
        end else begin
          dqm_next = 2'b00;
        end
      end
      ST_RD_DONE: begin
        rdy_next = 1'b1;
        if (RD_TAIL == 0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next   = 16'(RD_TAIL - 1);
          state_next = ST_RD_TAIL;
        end
      end
      ST_RD_TAIL: if (cnt_zero) state_next = ST_IDLE;
      ST_WR_WAIT: if (cnt_zero) begin
        rdy_next   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_INIT_WAIT;
    endcase

    // Refresh timer runs in every state once initialised. A new expiry wins
    // over the clear so a refresh is never lost on a coincident cycle.
    ref_expire    = init_done_reg && (ref_cnt_reg == 16'd1);
    ref_cnt_next  = !init_done_reg ? ref_cnt_reg :
                    ref_expire     ? 16'(REF_CYCLES) : ref_cnt_reg - 16'd1;
    ref_pend_next = (ref_pend_reg && !ref_issue) || ref_expire;
  end

  assign bus.ack      = ack_reg;
  assign bus.data_dst = dst_reg;
  assign bus.data_rdy = rdy_reg;
  assign bus.dout     = dout_reg;
  assign init_done    = init_done_reg;

  assign sdram_cs_n   = 1'b0;
  assign sdram_ras_n  = cmd_reg[2];
  assign sdram_cas_n  = cmd_reg[1];
  assign sdram_we_n   = cmd_reg[0];
  assign sdram_ba     = 2'(BANK);
  assign sdram_a      = a_reg;
  assign sdram_dqm    = dqm_reg;
  assign sdram_dq_out = dq_out_reg;
  assign sdram_dq_oe  = dq_oe_reg;

endmodule

// File: tb/tb_jtframe_sdram_1bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jtframe_sdram_1bank_ctrl
// Directed bench for the single-bank SDRAM controller (INIT_WAIT=8,
// REF_CYCLES=20, CL=2). A small SDRAM model stores writes and returns read
// data on the pad for exactly one cycle; a refresh-timer model flags any
// ACTIVE issued while a refresh should be pending.
// ----------------------------------------------------------------------------
module tb_jtframe_sdram_1bank_ctrl;

  localparam int CL   = 2;
  localparam int TRFC = 7;
  localparam int REFC = 20;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_ACT  = 3'b011;
  localparam logic [2:0] CMD_RD   = 3'b101;
  localparam logic [2:0] CMD_WR   = 3'b100;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_REF  = 3'b001;
  localparam logic [2:0] CMD_MODE = 3'b000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic [15:0] sdram_dq_in = 16'hDEAD;
  logic [2:0]  cmd;

  int checks = 0;
  int failures = 0;

  jtframe_sdram_1bank_ctrl_if #(.SDRAMW(22)) bus ();

  jtframe_sdram_1bank_ctrl #(
    .INIT_WAIT  (8),
    .REF_CYCLES (REFC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .init_done    (init_done),
    .sdram_cs_n   (sdram_cs_n),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_ba     (sdram_ba),
    .sdram_a      (sdram_a),
    .sdram_dqm    (sdram_dqm),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe),
    .sdram_dq_in  (sdram_dq_in)
  );

  always #5 clk = ~clk;

  assign cmd = {sdram_ras_n, sdram_cas_n, sdram_we_n};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- SDRAM + refresh-timer model ----------------
  logic [15:0] mem [int];
  logic [12:0] mrow;
  logic [15:0] rd_data, wdata;
  int          rd_cnt, key, mcnt, since_ref;
  logic        mpend, mprev_init, pend_before, expire;

  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = REFC; mpend = 1'b0; mprev_init = 1'b0;
      since_ref = 1000; rd_cnt = 0; sdram_dq_in = 16'hDEAD;
    end else begin
      sdram_dq_in = 16'hDEAD;
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) sdram_dq_in = rd_data;
      end
      key = int'({mrow, sdram_a[8:0]});
      case (cmd)
        CMD_ACT: mrow = sdram_a;
        CMD_WR: begin
          wdata = mem.exists(key) ? mem[key] : 16'h0000;
          if (!sdram_dqm[0]) wdata[7:0]  = sdram_dq_out[7:0];
          if (!sdram_dqm[1]) wdata[15:8] = sdram_dq_out[15:8];
          mem[key] = wdata;
        end
        CMD_RD: begin
          rd_data = mem.exists(key) ? mem[key] : 16'h0000;
          rd_cnt  = CL;
        end
        default: ;
      endcase
      pend_before = mpend;
      expire      = 1'b0;
      if (mprev_init) begin
        if (mcnt == 1) begin expire = 1'b1; mcnt = REFC; end
        else mcnt--;
      end
      mpend = (mpend && !(cmd == CMD_REF && mprev_init)) || expire;
      if (cmd == CMD_ACT) check("ref_before_act", 32'(pend_before), 0);
      since_ref = (cmd == CMD_REF) ? 0 : since_ref + 1;
      if (bus.ack) check("ack_after_trfc", 32'(since_ref >= TRFC + 1), 1);
      mprev_init = init_done;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.ack;
      1:       return bus.data_dst;
      2:       return bus.data_rdy;
      default: return init_done;
    endcase
  endfunction

  task automatic wait_bit(input string tag, input int sel, input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!sig(sel) && n < budget);
    check(tag, 32'(sig(sel)), 1);
  endtask

  task automatic wait_cmd(input string tag, input logic [2:0] c, input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (cmd != c && n < budget);
    check(tag, 32'(cmd), 32'(c));
  endtask

  task automatic do_write(input logic [21:0] ad, input logic [15:0] d, input logic [1:0] m,
                          input logic also_rd, input logic [12:0] row, input logic [12:0] acol);
    int n;
    int dst_seen;
    bus.wr = 1'b1; bus.rd = also_rd; bus.addr = ad; bus.din = d; bus.wrmask = m;
    wait_bit("wr_ack", 0, 40, n);
    check("wr_act_cmd", 32'(cmd), 32'(CMD_ACT));
    check("wr_act_row", 32'(sdram_a), 32'(row));
    check("wr_act_ba", 32'(sdram_ba), 0);
    // Scramble inputs: the controller must use the values latched at ack
    bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '1; bus.din = 16'h0000; bus.wrmask = 2'b11;
    wait_cmd("wr_cmd", CMD_WR, 10, n);
    check("wr_trcd", 32'(n), 2);
    check("wr_a", 32'(sdram_a), 32'(acol));
    check("wr_oe", 32'(sdram_dq_oe), 1);
    check("wr_dqm", 32'(sdram_dqm), 32'(m));
    check("wr_dq", 32'(sdram_dq_out), 32'(d));
    @(negedge clk);
    n = 1;
    dst_seen = bus.data_dst ? 1 : 0;
    check("wr_oe_off", 32'(sdram_dq_oe), 0);
    check("wr_dqm_off", 32'(sdram_dqm), 2'b11);
    while (!bus.data_rdy && n < 10) begin
      @(negedge clk); n++;
      if (bus.data_dst) dst_seen++;
    end
    check("wr_rdy", 32'(bus.data_rdy), 1);
    check("wr_rdy_lat", 32'(n), 4);
    check("wr_no_dst", 32'(dst_seen), 0);
  endtask

  task automatic do_read(input logic [21:0] ad, input logic [12:0] row,
                         input logic [12:0] acol, input logic [15:0] exp_d);
    int n;
    bus.rd = 1'b1; bus.addr = ad;
    wait_bit("rd_ack", 0, 40, n);
    check("rd_act_cmd", 32'(cmd), 32'(CMD_ACT));
    check("rd_act_row", 32'(sdram_a), 32'(row));
    bus.rd = 1'b0; bus.addr = '1;
    wait_cmd("rd_cmd", CMD_RD, 10, n);
    check("rd_trcd", 32'(n), 2);
    check("rd_a", 32'(sdram_a), 32'(acol));
    check("rd_dqm", 32'(sdram_dqm), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.data_dst && n < 10);
    check("rd_dst", 32'(bus.data_dst), 1);
    check("rd_lat", 32'(n), 3);
    check("rd_dout", 32'(bus.dout), 32'(exp_d));
    @(negedge clk);
    check("rd_rdy", 32'(bus.data_rdy), 1);
    check("rd_dst_off", 32'(bus.data_dst), 0);
    check("rd_hold", 32'(bus.dout), 32'(exp_d));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, la, ld, lr, lref, bad, snap_dst, snap_rdy;
    logic dropped;

    rst_n = 1'b0;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.din = '0; bus.wrmask = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(sdram_cs_n), 0);
    check("rst_cmd", 32'(cmd), 32'(CMD_NOP));
    check("rst_a", 32'(sdram_a), 0);
    check("rst_ba", 32'(sdram_ba), 0);
    check("rst_dqm", 32'(sdram_dqm), 2'b11);
    check("rst_oe", 32'(sdram_dq_oe), 0);
    check("rst_pulses", {29'd0, bus.ack, bus.data_dst, bus.data_rdy}, 0);
    check("rst_init", 32'(init_done), 0);
    check("rst_dout", 32'(bus.dout), 0);

    // Initialisation, with a write request held that must be ignored
    rst_n = 1'b1;
    bus.wr = 1'b1; bus.addr = 22'h00001;
    n = 0; bad = 0;
    do begin @(negedge clk); n++; if (bus.ack) bad++; end while (cmd != CMD_PRE && n < 20);
    check("pre_cmd", 32'(cmd), 32'(CMD_PRE));
    check("pre_time", 32'(n), 8);
    check("pre_a10", 32'(sdram_a[10]), 1);
    wait_cmd("ref1_cmd", CMD_REF, 10, n);
    check("ref1_time", 32'(n), 2);
    wait_cmd("ref2_cmd", CMD_REF, 20, n);
    check("ref2_time", 32'(n), TRFC + 1);
    wait_cmd("mode_cmd", CMD_MODE, 20, n);
    check("mode_time", 32'(n), TRFC + 1);
    check("mode_a", 32'(sdram_a), 32'h0220);
    @(negedge clk);
    if (bus.ack) bad++;
    check("init_early", 32'(init_done), 0);
    @(negedge clk);
    if (bus.ack) bad++;
    check("init_done", 32'(init_done), 1);
    check("init_no_ack", 32'(bad), 0);
    bus.wr = 1'b0;

    // Basic write / read-back, masked write, rd+wr treated as write
    do_write(22'h12345, 16'hBEEF, 2'b00, 1'b0, 13'h0091, 13'h0545);
    do_read (22'h12345, 13'h0091, 13'h0545, 16'hBEEF);
    do_write(22'h12345, 16'h00AA, 2'b10, 1'b1, 13'h0091, 13'h0545);
    do_read (22'h12345, 13'h0091, 13'h0545, 16'hBEAA);
    // Top row, column 1, upper byte only into a fresh location
    do_write(22'h3FFE01, 16'h1234, 2'b01, 1'b0, 13'h1FFF, 13'h0401);
    do_read (22'h3FFE01, 13'h1FFF, 13'h0401, 16'h1200);

    // rd held continuously across several refresh periods
    bus.rd = 1'b1; bus.addr = 22'h12345;
    la = 0; ld = 0; lr = 0; lref = 0; dropped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cmd == CMD_REF) lref++;
      if (bus.data_dst) begin
        ld++;
        check("stress_dout", 32'(bus.dout), 32'hBEAA);
      end
      if (bus.ack) begin
        la++;
        if (i >= 150) begin bus.rd = 1'b0; dropped = 1'b1; end
      end
      if (bus.data_rdy) begin
        lr++;
        if (dropped) break;
      end
    end
    check("stress_done", 32'(dropped), 1);
    check("stress_rdy", 32'(lr), 32'(la));
    check("stress_dst", 32'(ld), 32'(la));
    check("stress_ref", 32'(lref >= 5), 1);

    // Reset one cycle after a READ: abort, re-init, read again
    repeat (2) @(negedge clk);
    bus.rd = 1'b1; bus.addr = 22'h12345;
    wait_bit("abort_ack", 0, 40, n);
    bus.rd = 1'b0;
    wait_cmd("abort_rd", CMD_RD, 10, n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_cmd", 32'(cmd), 32'(CMD_NOP));
    check("abort_dqm", 32'(sdram_dqm), 2'b11);
    check("abort_init", 32'(init_done), 0);
    check("abort_a", 32'(sdram_a), 0);
    snap_dst = 0; snap_rdy = 0;
    @(negedge clk);
    if (bus.data_dst) snap_dst++;
    if (bus.data_rdy) snap_rdy++;
    rst_n = 1'b1;
    bus.rd = 1'b1; bus.addr = 22'h12345;
    n = 0; bad = 0;
    do begin
      @(negedge clk); n++;
      if (bus.ack) bad++;
      if (bus.data_dst) snap_dst++;
      if (bus.data_rdy) snap_rdy++;
    end while (!init_done && n < 200);
    check("reinit_done", 32'(init_done), 1);
    check("reinit_no_ack", 32'(bad), 0);
    check("abort_no_dst", 32'(snap_dst), 0);
    check("abort_no_rdy", 32'(snap_rdy), 0);
    do_read(22'h12345, 13'h0091, 13'h0545, 16'hBEAA);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_sdram_1bank_ctrl.md
Name: jtframe_sdram_1bank_ctrl

Overview:
- Single-bank SDRAM command sequencer directly downstream of the 6-slot RAM/ROM arbiter.
- Consumes the arbiter's rd/wr/addr/data/wrmask request and returns ack, data_dst, data_rdy and read data.
- Drives the SDRAM command, address and DQ pins, including power-up initialisation and periodic auto-refresh.
- One 16-bit word per access; every access is ACTIVATE then READ/WRITE with auto-precharge.

Parameters:
SDRAMW, 22, request word-address width; addr = {row[SDRAMW-10:0], col[8:0]}
BANK, 0, fixed 2-bit bank driven on ba
CL, 2, CAS latency in cycles; legal values 2 or 3
TRCD, 2, ACTIVE-to-READ/WRITE cycles
TRP, 2, precharge cycles
TRFC, 7, auto-refresh cycles
TWR, 2, write recovery cycles before auto-precharge starts
REF_CYCLES, 374, cycles between refresh requests
INIT_WAIT, 9600, power-up idle cycles before PRECHARGE ALL

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rd  in  1  read request; held until ack
wr  in  1  write request; held until ack
addr  in  SDRAMW  word address
din  in  16  write data
wrmask  in  2  byte mask, active low-enable (1 = byte not written)
ack  out  1  one-cycle pulse: request accepted
data_dst  out  1  one-cycle pulse: read data valid on dout
data_rdy  out  1  one-cycle pulse: access complete
dout  out  16  registered read data
init_done  out  1  high once initialisation is complete
sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command pins
sdram_ba  out  2  bank address
sdram_a  out  13  row/column/mode address
sdram_dqm  out  2  data mask
sdram_dq_out  out  16  write data to pad
sdram_dq_oe  out  1  pad output enable
sdram_dq_in  in  16  read data from pad

Behaviour:
- Reset values:
  - Command pins NOP: cs_n=0, ras_n=cas_n=we_n=1.
  - a=0, ba=BANK, dqm=2'b11, dq_oe=0.
  - ack, data_dst, data_rdy, init_done all 0; dout=0.
  - State INIT_WAIT; refresh counter = REF_CYCLES; ref_pend=0.
- Asserting rst_n mid-operation aborts immediately to the reset values. No completion pulse is produced for the aborted access.
- Init sequence:
  - INIT_WAIT counts INIT_WAIT cycles.
  - PRECHARGE ALL (a[10]=1), wait TRP.
  - Two AUTO REFRESH, each followed by TRFC.
  - LOAD MODE: a = {3'b0, 1'b1 single-write, 2'b0, CL[2:0], 1'b0 sequential, 3'b000 burst 1}, then 2-cycle wait.
  - IDLE; init_done=1 from this point.
  - rd/wr are ignored (no ack) before init_done.
- Refresh:
  - After init_done the counter decrements every cycle in all states.
  - At 1 it sets ref_pend and reloads REF_CYCLES.
  - A second expiry while ref_pend=1 leaves ref_pend at 1; no queueing.
- IDLE priority: ref_pend > wr > rd.
  - Refresh: AUTO REFRESH, clear ref_pend, wait TRFC, back to IDLE.
  - Request: issue ACTIVE with a=row, ba=BANK, and ack=1 the same cycle. addr/din/wrmask are latched on this edge; later changes are ignored.
  - rd and wr both high is treated as a write.
- Read path:
  - After TRCD: READ with a = {2'b0, 1'b1, col} (A10 auto-precharge), dqm=00.
  - Capture sdram_dq_in into dout exactly CL+1 cycles after the READ edge; data_dst=1 that cycle.
  - data_rdy=1 the following cycle; dout holds until the next capture.
  - Then wait out the remainder of TRP and return to IDLE.
- Write path:
  - After TRCD: WRITE with the same column/A10 encoding, dq_oe=1, dq_out=din, dqm=wrmask. dq_oe is high only in that cycle.
  - Wait TWR+TRP; data_rdy=1 on the last wait cycle. data_dst is never pulsed for writes.
- Outside READ/WRITE data phases dqm=11 and the command is NOP.
- ack, data_dst, data_rdy are exactly one cycle wide. At most one access is outstanding.
- Minimum turnaround: a new ACTIVE may issue the cycle after data_rdy.

Test Plan:
- Reset/init (INIT_WAIT=8) -> after 8 cycles: PRECHARGE with a[10]=1; two REFRESH TRFC+1 apart; LOAD MODE a=13'h0220 (CL=2); init_done=1.
- Write addr=22'h12345, din=16'hBEEF, wrmask=00 -> ack with ACTIVE row 13'h91, ba=0; WRITE 2 cycles later with a=13'h0545, dq_oe=1, dqm=00; data_rdy 4 cycles after WRITE.
- Read the same address with a model returning 16'hBEEF (CL=2) -> data_dst and dout=16'hBEEF 3 cycles after READ; data_rdy the next cycle.
- Write wrmask=2'b10, din=16'h00AA -> dqm=10 on the WRITE cycle; the model then reads back 16'hBEAA.
- REF_CYCLES=20 with rd held continuously -> AUTO REFRESH issued before the next ACTIVE whenever ref_pend; no ack during TRFC; no read lost.
- rst_n pulsed low 1 cycle after a READ -> pins return to NOP immediately, no data_dst/data_rdy; re-init completes and a subsequent read succeeds.
